// File: rtl/z80_int_ctrl.sv
// z80_int_ctrl: interrupt merger for the Z80 /INT pin.
// Combines the 16550 level interrupt with a periodic frame-tick timer, drives
// /INT, returns an IM2 vector during interrupt acknowledge and exposes a small
// control/status and vector-base register pair on the Z80 I/O bus.
module z80_int_ctrl #(
   parameter int          TICK_DIV  = 480000,
   parameter logic [7:0]  PORT_CTRL = 8'h12,
   parameter logic [7:0]  PORT_VEC  = 8'h13
) (
   input  logic       CLK_24MHz,
   input  logic       RES,
   input  logic       M1,
   input  logic       IORQ,
   input  logic       RD,
   input  logic       WR,
   input  logic [7:0] A,
   input  logic [7:0] D_in,
   input  logic       U_INT,
   output logic       INT,
   output logic [7:0] D_out,
   output logic       D_oe
);

   localparam int             CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0]  TC = CW'(TICK_DIV - 1);
   // idle values of {U_INT, WR, RD, IORQ, M1}
   localparam logic [4:0]     SYNC_IDLE = 5'b01111;

   logic [4:0]    sync1, sync2;
   logic [1:0]    fill;
   logic          sync_valid;
   logic          m1_s, iorq_s, rd_s, wr_s, u_int_s;
   logic          iowr_c, iord_c, ack_c;
   logic          iowr_q, iord_q, ack_q;
   logic          iowr_e, iord_e, ack_e;
   logic          wr_ctrl, wr_vec, rd_ctrl, rd_vec;
   logic          clr, tick, tack;
   logic [CW-1:0] count;
   logic [1:0]    en;
   logic [4:0]    vbase;
   logic          tpend, tovr;
   logic [1:0]    ack_src, src_next;
   logic          rd_act;
   logic          unused_bits;

   assign unused_bits = D_in[2];

   // two-flop synchronizers for the asynchronous bus strobes and U_INT
   always_ff @(posedge CLK_24MHz or posedge RES) begin
      if (RES) begin
         sync1 <= SYNC_IDLE;
         sync2 <= SYNC_IDLE;
         fill  <= 2'b00;
      end else begin
         sync1 <= {U_INT, WR, RD, IORQ, M1};
         sync2 <= sync1;
         fill  <= {fill[0], 1'b1};
      end
   end

   assign sync_valid = fill[1];
   assign m1_s       = sync2[0];
   assign iorq_s     = sync2[1];
   assign rd_s       = sync2[2];
   assign wr_s       = sync2[3];
   assign u_int_s    = sync2[4];

   assign iowr_c = ~iorq_s & ~wr_s & m1_s;
   assign iord_c = ~iorq_s & ~rd_s & m1_s;
   assign ack_c  = ~iorq_s & ~m1_s;

   // previous cycle-type values for one-shot edge detection
   always_ff @(posedge CLK_24MHz or posedge RES) begin
      if (RES) begin
         iowr_q <= 1'b0;
         iord_q <= 1'b0;
         ack_q  <= 1'b0;
      end else begin
         iowr_q <= iowr_c;
         iord_q <= iord_c;
         ack_q  <= ack_c;
      end
   end

   assign iowr_e  = sync_valid & iowr_c & ~iowr_q;
   assign iord_e  = sync_valid & iord_c & ~iord_q;
   assign ack_e   = sync_valid & ack_c & ~ack_q;
   assign wr_ctrl = iowr_e & (A == PORT_CTRL);
   assign wr_vec  = iowr_e & (A == PORT_VEC);
   assign rd_ctrl = iord_e & (A == PORT_CTRL);
   assign rd_vec  = iord_e & (A == PORT_VEC);

   assign src_next = (u_int_s & en[0]) ? 2'd0 :
                     (tpend & en[1])   ? 2'd1 : 2'd3;
   assign clr  = wr_ctrl & D_in[7];
   assign tack = ack_e & (src_next == 2'd1);
   assign tick = (count == TC);

   // free-running frame timer, ticks on the wrap back to zero
   always_ff @(posedge CLK_24MHz or posedge RES) begin
      if (RES)       count <= '0;
      else if (tick) count <= '0;
      else           count <= count + 1'b1;
   end

   // enable, vector base and acknowledge source registers
   always_ff @(posedge CLK_24MHz or posedge RES) begin
      if (RES) begin
         en      <= 2'b00;
         vbase   <= 5'd0;
         ack_src <= 2'd0;
      end else begin
         if (wr_ctrl) en <= D_in[1:0];
         if (wr_vec)  vbase <= D_in[7:3];
         if (ack_e)   ack_src <= src_next;
      end
   end

   // timer pending / overrun; a tick beats both a clear and a timer ack
   always_ff @(posedge CLK_24MHz or posedge RES) begin
      if (RES) begin
         tpend <= 1'b0;
         tovr  <= 1'b0;
      end else if (tick) begin
         tpend <= 1'b1;
         if (tpend && !clr && !tack) tovr <= 1'b1;
      end else if (clr) begin
         tpend <= 1'b0;
         tovr  <= 1'b0;
      end else if (tack) begin
         tpend <= 1'b0;
      end
   end

   // read data / vector capture and bus-drive window
   always_ff @(posedge CLK_24MHz or posedge RES) begin
      if (RES) begin
         D_out  <= 8'h00;
         rd_act <= 1'b0;
      end else begin
         if (rd_ctrl)     D_out <= {4'b0000, en[1], tovr, tpend, u_int_s};
         else if (rd_vec) D_out <= {vbase, 3'b000};
         else if (ack_e)  D_out <= {vbase, src_next, 1'b0};
         if (rd_ctrl || rd_vec || ack_e) rd_act <= 1'b1;
         else if (!(iord_c || ack_c))    rd_act <= 1'b0;
      end
   end

   // raw IORQ gates the drive so the bus is released without sync delay
   assign D_oe = rd_act & ~IORQ;

   // registered active-low interrupt request
   always_ff @(posedge CLK_24MHz or posedge RES) begin
      if (RES) INT <= 1'b1;
      else     INT <= ~((u_int_s & en[0]) | (tpend & en[1]));
   end

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Self-checking bench for z80_int_ctrl with a transaction-level register model.
module tb_z80_int_ctrl;

   localparam int TDIV = 100;

   logic       CLK_24MHz = 1'b0;
   logic       RES = 1'b1;
   logic       M1 = 1'b1, IORQ = 1'b1, RD = 1'b1, WR = 1'b1;
   logic [7:0] A = 8'h00, D_in = 8'h00;
   logic       U_INT = 1'b0;
   logic       INT;
   logic [7:0] D_out;
   logic       D_oe;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model state
   int         cyc = 0;
   logic [1:0] m_en = 2'b00;
   logic [4:0] m_vb = 5'd0;
   logic       m_tpend = 1'b0;
   logic       m_tovr = 1'b0;

   z80_int_ctrl #(.TICK_DIV(TDIV), .PORT_CTRL(8'h12), .PORT_VEC(8'h13)) dut (
      .CLK_24MHz(CLK_24MHz), .RES(RES), .M1(M1), .IORQ(IORQ), .RD(RD),
      .WR(WR), .A(A), .D_in(D_in), .U_INT(U_INT), .INT(INT),
      .D_out(D_out), .D_oe(D_oe)
   );

   always #5 CLK_24MHz = ~CLK_24MHz;

   // model: one timer tick every TDIV clocks after reset release
   always @(posedge CLK_24MHz) begin
      if (RES) cyc = 0;
      else begin
         cyc = cyc + 1;
         if (cyc % TDIV == 0) begin
            if (m_tpend) m_tovr = 1'b1;
            m_tpend = 1'b1;
         end
      end
   end

   function automatic logic [7:0] exp_status();
      return {4'b0000, m_en[1], m_tovr, m_tpend, U_INT};
   endfunction

   function automatic logic exp_int();
      return ~((U_INT & m_en[0]) | (m_tpend & m_en[1]));
   endfunction

   // keep bus transactions well clear of a timer tick
   task automatic avoid_tick();
      while ((cyc % TDIV) < 2 || (cyc % TDIV) > 80) @(negedge CLK_24MHz);
   endtask

   task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
      avoid_tick();
      if (a == 8'h12) begin
         m_en = d[1:0];
         if (d[7]) begin m_tpend = 1'b0; m_tovr = 1'b0; end
      end else if (a == 8'h13) begin
         m_vb = d[7:3];
      end
      A = a; D_in = d; IORQ = 1'b0; WR = 1'b0;
      repeat (4) @(negedge CLK_24MHz);
      IORQ = 1'b1; WR = 1'b1;
      repeat (4) @(negedge CLK_24MHz);
   endtask

   task automatic io_rd(input logic [7:0] a, output logic [7:0] exp_d,
                        output logic [7:0] d, output logic oe, output logic oe_rel);
      avoid_tick();
      A = a; IORQ = 1'b0; RD = 1'b0;
      exp_d = (a == 8'h12) ? exp_status() : {m_vb, 3'b000};
      repeat (4) @(negedge CLK_24MHz);
      d = D_out; oe = D_oe;
      IORQ = 1'b1;
      #1 oe_rel = D_oe;
      RD = 1'b1;
      repeat (4) @(negedge CLK_24MHz);
   endtask

   task automatic int_ack(output logic [7:0] exp_v, output logic [7:0] v,
                          output logic oe, output logic oe_rel);
      logic [1:0] src;
      avoid_tick();
      if (U_INT && m_en[0])         src = 2'd0;
      else if (m_tpend && m_en[1])  src = 2'd1;
      else                          src = 2'd3;
      if (src == 2'd1) m_tpend = 1'b0;
      exp_v = {m_vb, src, 1'b0};
      M1 = 1'b0;
      @(negedge CLK_24MHz);
      IORQ = 1'b0;
      repeat (4) @(negedge CLK_24MHz);
      v = D_out; oe = D_oe;
      IORQ = 1'b1;
      #1 oe_rel = D_oe;
      @(negedge CLK_24MHz);
      M1 = 1'b1;
      repeat (4) @(negedge CLK_24MHz);
   endtask

   task automatic test_reset();
      logic [7:0] e, d;
      logic oe, oer;
      RES = 1'b1;
      repeat (5) @(negedge CLK_24MHz);
      n_cmp++;
      if (INT !== 1'b1) begin n_fail++; $display("FAIL reset_int: got %b want 1", INT); end
      n_cmp++;
      if (D_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", D_oe); end
      RES = 1'b0;
      m_en = 2'b00; m_vb = 5'd0; m_tpend = 1'b0; m_tovr = 1'b0;
      repeat (3) @(negedge CLK_24MHz);
      io_rd(8'h12, e, d, oe, oer);
      n_cmp++;
      if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", d); end
      n_cmp++;
      if (oe !== 1'b1) begin n_fail++; $display("FAIL reset_read_oe: got %b want 1", oe); end
   endtask

   task automatic test_uart();
      logic [7:0] e, v;
      logic oe, oer;
      int k;
      io_wr(8'h12, 8'h01);
      io_wr(8'h13, 8'hF8);
      avoid_tick();
      U_INT = 1'b1;
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge CLK_24MHz);
         if (INT === 1'b0) begin k = i; break; end
      end
      n_cmp++;
      if (k != 3) begin n_fail++; $display("FAIL uart_int_latency: got %0d want 3", k); end
      int_ack(e, v, oe, oer);
      n_cmp++;
      if (v !== 8'hF8 || v !== e) begin n_fail++; $display("FAIL uart_vector: got %h want F8/%h", v, e); end
      n_cmp++;
      if (oe !== 1'b1) begin n_fail++; $display("FAIL uart_ack_oe: got %b want 1", oe); end
      n_cmp++;
      if (oer !== 1'b0) begin n_fail++; $display("FAIL uart_oe_release: got %b want 0", oer); end
      n_cmp++;
      if (INT !== 1'b0) begin n_fail++; $display("FAIL uart_int_held: got %b want 0", INT); end
      avoid_tick();
      U_INT = 1'b0;
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge CLK_24MHz);
         if (INT === 1'b1) begin k = i; break; end
      end
      n_cmp++;
      if (k != 3) begin n_fail++; $display("FAIL uart_int_release: got %0d want 3", k); end
   endtask

   task automatic test_timer();
      logic [7:0] e, v;
      logic oe, oer;
      int k;
      io_wr(8'h12, 8'h82);
      n_cmp++;
      if (INT !== 1'b1) begin n_fail++; $display("FAIL timer_int_idle: got %b want 1", INT); end
      k = -1;
      for (int i = 0; i < 250; i++) begin
         @(negedge CLK_24MHz);
         if (INT === 1'b0) begin k = cyc % TDIV; break; end
      end
      n_cmp++;
      if (k != 1) begin n_fail++; $display("FAIL timer_int_at_wrap: phase got %0d want 1", k); end
      int_ack(e, v, oe, oer);
      n_cmp++;
      if (v !== 8'hFA || v !== e) begin n_fail++; $display("FAIL timer_vector: got %h want FA/%h", v, e); end
      n_cmp++;
      if (INT !== 1'b1) begin n_fail++; $display("FAIL timer_int_after_ack: got %b want 1", INT); end
      io_rd(8'h12, e, v, oe, oer);
      n_cmp++;
      if (v !== e) begin n_fail++; $display("FAIL timer_status: got %h want %h", v, e); end
   endtask

   task automatic test_priority();
      logic [7:0] e, v;
      logic oe, oer;
      int k;
      io_wr(8'h13, 8'hF8);
      io_wr(8'h12, 8'h03);
      U_INT = 1'b1;
      k = 0;
      for (int i = 0; i < 250 && !m_tpend; i++) @(negedge CLK_24MHz);
      n_cmp++;
      if (m_tpend !== 1'b1) begin n_fail++; $display("FAIL prio_wait_tick: got %b want 1", m_tpend); end
      int_ack(e, v, oe, oer);
      n_cmp++;
      if (v !== 8'hF8 || v !== e) begin n_fail++; $display("FAIL prio_vector: got %h want F8/%h", v, e); end
      io_rd(8'h12, e, v, oe, oer);
      n_cmp++;
      if (v !== e || v[1] !== 1'b1) begin n_fail++; $display("FAIL prio_tpend_kept: got %h want %h", v, e); end
      io_wr(8'h12, 8'h00);
      int_ack(e, v, oe, oer);
      n_cmp++;
      if (v !== 8'hFE || v !== e) begin n_fail++; $display("FAIL spurious_vector: got %h want FE/%h", v, e); end
      n_cmp++;
      if (INT !== 1'b1) begin n_fail++; $display("FAIL spurious_int: got %b want 1", INT); end
      U_INT = 1'b0;
      repeat (4) @(negedge CLK_24MHz);
   endtask

   task automatic test_overrun();
      logic [7:0] e, v;
      logic oe, oer;
      io_wr(8'h12, 8'h82);
      repeat (2 * TDIV + 10) @(negedge CLK_24MHz);
      io_rd(8'h12, e, v, oe, oer);
      n_cmp++;
      if (v !== 8'h0E || v !== e) begin n_fail++; $display("FAIL overrun_status: got %h want 0E/%h", v, e); end
      io_wr(8'h12, 8'h82);
      io_rd(8'h12, e, v, oe, oer);
      n_cmp++;
      if (v !== 8'h08 || v !== e) begin n_fail++; $display("FAIL clear_status: got %h want 08/%h", v, e); end
      n_cmp++;
      if (INT !== 1'b1) begin n_fail++; $display("FAIL clear_int: got %b want 1", INT); end
   endtask

   task automatic test_mid_reset();
      logic [7:0] e, v;
      logic oe, oer;
      io_wr(8'h13, 8'hA8);
      io_wr(8'h12, 8'h03);
      U_INT = 1'b1;
      repeat (4) @(negedge CLK_24MHz);
      avoid_tick();
      M1 = 1'b0;
      @(negedge CLK_24MHz);
      IORQ = 1'b0;
      repeat (4) @(negedge CLK_24MHz);
      n_cmp++;
      if (D_oe !== 1'b1) begin n_fail++; $display("FAIL midrst_oe_before: got %b want 1", D_oe); end
      n_cmp++;
      if (INT !== 1'b0) begin n_fail++; $display("FAIL midrst_int_before: got %b want 0", INT); end
      #2 RES = 1'b1;
      #1;
      n_cmp++;
      if (D_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_oe: got %b want 0", D_oe); end
      n_cmp++;
      if (INT !== 1'b1) begin n_fail++; $display("FAIL midrst_int: got %b want 1", INT); end
      m_en = 2'b00; m_vb = 5'd0; m_tpend = 1'b0; m_tovr = 1'b0;
      U_INT = 1'b0;
      @(negedge CLK_24MHz);
      IORQ = 1'b1; M1 = 1'b1;
      repeat (3) @(negedge CLK_24MHz);
      RES = 1'b0;
      repeat (3) @(negedge CLK_24MHz);
      io_rd(8'h13, e, v, oe, oer);
      n_cmp++;
      if (v !== 8'h00 || v !== e) begin n_fail++; $display("FAIL midrst_vbase: got %h want 00/%h", v, e); end
      io_rd(8'h12, e, v, oe, oer);
      n_cmp++;
      if (v !== 8'h00 || v !== e) begin n_fail++; $display("FAIL midrst_en: got %h want 00/%h", v, e); end
   endtask

   task automatic test_random();
      logic [7:0] e, v, a;
      logic oe, oer;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 6))
            0: io_wr(8'h12, 8'($urandom_range(0, 255)));
            1: io_wr(8'h13, 8'($urandom_range(0, 255)));
            2: begin
               a = 8'($urandom_range(0, 255));
               if (a == 8'h12 || a == 8'h13) a = 8'h20;
               io_wr(a, 8'($urandom_range(0, 255)));
               io_rd(a, e, v, oe, oer);
               n_cmp++;
               if (oe !== 1'b0) begin n_fail++; $display("FAIL rnd_other_oe: addr %h got %b want 0", a, oe); end
            end
            3: begin
               io_rd(8'h12, e, v, oe, oer);
               n_cmp++;
               if (v !== e || oe !== 1'b1 || oer !== 1'b0) begin
                  n_fail++; $display("FAIL rnd_status: got %h oe %b/%b want %h oe 1/0", v, oe, oer, e);
               end
            end
            4: begin
               io_rd(8'h13, e, v, oe, oer);
               n_cmp++;
               if (v !== e || oe !== 1'b1) begin n_fail++; $display("FAIL rnd_vec: got %h oe %b want %h", v, oe, e); end
            end
            5: begin
               int_ack(e, v, oe, oer);
               n_cmp++;
               if (v !== e || oe !== 1'b1 || oer !== 1'b0) begin
                  n_fail++; $display("FAIL rnd_ack: got %h oe %b/%b want %h oe 1/0", v, oe, oer, e);
               end
            end
            default: begin
               avoid_tick();
               U_INT = ~U_INT;
               repeat (4) @(negedge CLK_24MHz);
            end
         endcase
         n_cmp++;
         if (INT !== exp_int()) begin n_fail++; $display("FAIL rnd_int: step %0d got %b want %b", i, INT, exp_int()); end
      end
   endtask

   initial begin
      test_reset();
      test_uart();
      test_timer();
      test_priority();
      test_overrun();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
